// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared types, constants and the float zero test for the Maxnet sequencer.
package maxnet_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ACC, S_UPD, S_DONE} state_t;
    localparam int NUM_PU = 4;
    localparam logic [31:0] FP_ZERO = 32'h0;
    // Magnitude-only test so that -0 (80000000) is treated as zero.
    function automatic logic fp_is_zero(input logic [31:0] x);
        return x[30:0] == 31'h0;
    endfunction
endpackage

// File: rtl/maxnet_seq_ld_reg32.sv
// ld_reg32: 32-bit load-enable register with asynchronous active-low clear.
//   clk, rst (active-low async clear), i_ld (load enable), i_d (data in), o_q (registered value).
module ld_reg32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ld,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) o_q <= '0;
        else if (i_ld) o_q <= i_d;
endmodule

// File: rtl/maxnet_seq_nz_count4.sv
// nz_count4: counts nonzero floats among four values and reports the lowest nonzero index.
//   i_x (four 32-bit values, index 0 first), o_nz (nonzero count 0..4), o_idx (lowest nonzero index).
module nz_count4 import maxnet_pkg::*; (
    input  logic [NUM_PU-1:0][31:0] i_x,
    output logic [2:0]              o_nz,
    output logic [1:0]              o_idx
);
    always_comb begin
        o_nz  = '0;
        o_idx = '0;
        // Scanning downward lets the lowest nonzero index be the last one written.
        for (int k = NUM_PU - 1; k >= 0; k--) begin
            if (!fp_is_zero(i_x[k])) begin
                o_nz  = o_nz + 3'd1;
                o_idx = 2'(k);
            end
        end
    end
endmodule

// File: rtl/maxnet_seq.sv
// maxnet_seq: sequencer and activation feeder for the four-PU Maxnet layer.
//   clk, rst (async active-low), start (begin run in IDLE/DONE), in1..in4 (initial activations),
//   pu_out1..pu_out4 (ReLU outputs of the PUs), a1..a4 (activation bus), ldM / ldRes (PU load strobes),
//   busy (LOAD..UPD), done (pulse on DONE entry), winner / result (sole nonzero activation),
//   none (all zero), timeout (iteration cap hit), iter_count (iterations in current/last run).
//   All outputs are registered.
module maxnet_seq import maxnet_pkg::*; #(
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       in1,
    input  logic [31:0]       in2,
    input  logic [31:0]       in3,
    input  logic [31:0]       in4,
    input  logic [31:0]       pu_out1,
    input  logic [31:0]       pu_out2,
    input  logic [31:0]       pu_out3,
    input  logic [31:0]       pu_out4,
    output logic [31:0]       a1,
    output logic [31:0]       a2,
    output logic [31:0]       a3,
    output logic [31:0]       a4,
    output logic              ldM,
    output logic              ldRes,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic [31:0]       result,
    output logic              none,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);
    state_t                   r_state, w_next;
    logic [NUM_PU-1:0][31:0]  w_in, w_pu, r_act;
    logic [2:0]               w_nz;
    logic [1:0]               w_idx;
    logic [ITER_W-1:0]        w_iter_inc;
    logic                     w_go, w_upd, w_last;

    assign w_in       = {in4, in3, in2, in1};
    assign w_pu       = {pu_out4, pu_out3, pu_out2, pu_out1};
    assign w_go       = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_upd      = r_state == S_UPD;
    assign w_iter_inc = iter_count + 1'b1;
    assign w_last     = w_iter_inc == ITER_W'(MAX_ITER);

    // The UPD decision looks at the live PU outputs, not the registered copies.
    nz_count4 u_nz (
        .i_x   (w_pu),
        .o_nz  (w_nz),
        .o_idx (w_idx)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = start ? S_LOAD : r_state;
            S_LOAD:         w_next = S_MUL;
            S_MUL:          w_next = S_ACC;
            S_ACC:          w_next = S_UPD;
            S_UPD:          w_next = (w_nz <= 3'd1 || w_last) ? S_DONE : S_MUL;
            default:        w_next = S_IDLE;
        endcase
    end

    // Strobes and status are registered from the next state so they line up with the state they mark.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            ldM        <= 1'b0;
            ldRes      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            winner     <= '0;
            none       <= 1'b0;
            timeout    <= 1'b0;
            iter_count <= '0;
        end else begin
            r_state <= w_next;
            ldM     <= w_next == S_MUL;
            ldRes   <= w_next == S_ACC;
            busy    <= w_next inside {S_LOAD, S_MUL, S_ACC, S_UPD};
            done    <= w_upd && w_next == S_DONE;
            if (w_go) begin
                iter_count <= '0;
                winner     <= '0;
                none       <= 1'b0;
                timeout    <= 1'b0;
            end else if (w_upd) begin
                iter_count <= w_iter_inc;
                if (w_nz == 3'd1) winner <= w_idx;
                none    <= w_nz == 3'd0;
                timeout <= w_nz > 3'd1 && w_last;
            end
        end
    end

    ld_reg32 u_res (
        .clk  (clk),
        .rst  (rst),
        .i_ld (w_go || (w_upd && w_nz == 3'd1)),
        .i_d  (w_go ? FP_ZERO : w_pu[w_idx]),
        .o_q  (result)
    );

    for (genvar i = 0; i < NUM_PU; i++) begin : g_act
        ld_reg32 u_act (
            .clk  (clk),
            .rst  (rst),
            .i_ld (r_state == S_LOAD || w_upd),
            .i_d  (w_upd ? w_pu[i] : w_in[i]),
            .o_q  (r_act[i])
        );
    end

    assign a1 = r_act[0];
    assign a2 = r_act[1];
    assign a3 = r_act[2];
    assign a4 = r_act[3];
endmodule

// File: tb/tb_maxnet_seq.sv
// tb_maxnet_seq: self-checking bench with four behavioural PUs around the Maxnet sequencer.
module tb_maxnet_seq;
    localparam int MAX_ITER = 16;
    typedef logic [3:0][31:0] vec_t;
    typedef struct {
        vec_t        iv;
        logic        ovr;
        vec_t        ov;
        logic [1:0]  w;
        logic [31:0] r;
        logic        n;
        logic        t;
        int          it;
        int          dc;
    } row_t;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, ovr = 1'b0;
    vec_t        iv = '0, ov = '0, pu_v, a_v;
    logic        ldM, ldRes, busy, done, none, timeout;
    logic [1:0]  winner;
    logic [31:0] result;
    logic [4:0]  iter_count;
    int          tests = 0, fails = 0;
    logic        c1_busy;
    logic [3:0]  c1_flags;
    real         m [4][4];
    real         res [4];
    row_t        tbl [8];

    always #5 clk = ~clk;

    maxnet_seq #(.MAX_ITER(MAX_ITER), .ITER_W(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in1(iv[0]), .in2(iv[1]), .in3(iv[2]), .in4(iv[3]),
        .pu_out1(pu_v[0]), .pu_out2(pu_v[1]), .pu_out3(pu_v[2]), .pu_out4(pu_v[3]),
        .a1(a_v[0]), .a2(a_v[1]), .a3(a_v[2]), .a4(a_v[3]),
        .ldM(ldM), .ldRes(ldRes), .busy(busy), .done(done),
        .winner(winner), .result(result), .none(none), .timeout(timeout),
        .iter_count(iter_count)
    );

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h0) return 0.0;
        d = '0;
        d[63] = f[31];
        d[62:52] = 11'(f[30:23]) + 11'd896;
        d[51:29] = f[22:0];
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e <= 0) return {d[63], 31'h0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic real wt(input int i, input int j);
        return (i == j) ? 1.0 : -0.25;
    endfunction

    function automatic vec_t mk(input logic [31:0] x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    // Processing units: product register on ldM, row sum on ldRes, ReLU on the output.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                res[i] <= 0.0;
                for (int j = 0; j < 4; j++) m[i][j] <= 0.0;
            end
        end else begin
            if (ldM)
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) m[i][j] <= f2r(a_v[j]) * wt(i, j);
            if (ldRes)
                for (int i = 0; i < 4; i++) res[i] <= ((m[i][0] + m[i][1]) + m[i][2]) + m[i][3];
        end
    end

    always_comb
        for (int i = 0; i < 4; i++) pu_v[i] = ovr ? ov[i] : (res[i] > 0.0 ? r2f(res[i]) : 32'h0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole-run reference: iterate the layer on vectors and apply the stop rules.
    task automatic model(input vec_t v, output logic [1:0] w, output logic [31:0] r,
                         output logic n, output logic t, output int it, output vec_t fin);
        vec_t cur, nx;
        int nz, first;
        real s;
        cur = v; w = 0; r = 0; n = 0; t = 0; it = 0;
        for (int k = 1; k <= MAX_ITER; k++) begin
            nz = 0; first = -1;
            for (int i = 0; i < 4; i++) begin
                s = ((f2r(cur[0]) * wt(i, 0) + f2r(cur[1]) * wt(i, 1)) + f2r(cur[2]) * wt(i, 2))
                    + f2r(cur[3]) * wt(i, 3);
                nx[i] = s > 0.0 ? r2f(s) : 32'h0;
                if (nx[i][30:0] != 31'h0) begin
                    nz++;
                    if (first < 0) first = i;
                end
            end
            cur = nx; it = k;
            if (nz == 1) begin w = 2'(first); r = nx[first]; break; end
            if (nz == 0) begin n = 1; break; end
            if (k == MAX_ITER) t = 1;
        end
        fin = cur;
    endtask

    task automatic run(input vec_t v, input int poke, input vec_t pv, output int dc);
        iv = v;
        @(negedge clk);
        start = 1'b1;
        dc = -1;
        for (int c = 1; c <= 80 && dc < 0; c++) begin
            @(negedge clk);
            start = (c == poke);
            if (c == poke) iv = pv;
            if (c == 1) begin
                c1_busy  = busy;
                c1_flags = {none | timeout, |iter_count, |winner, |result};
            end
            if (ldM && ldRes) begin
                fails++;
                $display("FAIL ld_excl: ldM and ldRes both high in cycle %0d", c);
            end
            if (done) dc = c;
        end
    endtask

    initial begin
        int dc, eit;
        logic [1:0] ew;
        logic [31:0] er;
        logic en, et;
        vec_t fin, v;
        tbl[0] = '{mk(32'h3F800000, 32'h3F000000, 0, 0), 0, '0, 0, 32'h3F4E0000, 0, 0, 3, 11};
        tbl[1] = '{mk(32'h3F800000, 32'h3F800000, 0, 0), 0, '0, 0, 32'h0, 0, 1, 16, 50};
        tbl[2] = '{mk(0, 0, 0, 0), 0, '0, 0, 32'h0, 1, 0, 1, 5};
        tbl[3] = '{mk(32'h80000000, 32'h3F800000, 0, 0), 0, '0, 1, 32'h3F800000, 0, 0, 1, 5};
        tbl[4] = '{mk(0, 0, 32'h40000000, 0), 0, '0, 2, 32'h40000000, 0, 0, 1, 5};
        tbl[5] = '{mk(32'hBF800000, 0, 0, 32'h3F800000), 0, '0, 3, 32'h3FA00000, 0, 0, 1, 5};
        tbl[6] = '{mk(32'h3F800000, 0, 0, 0), 1, mk(32'h80000000, 0, 0, 32'h40000000), 3, 32'h40000000, 0, 0, 1, 5};
        tbl[7] = '{mk(32'h3F800000, 0, 0, 0), 1, mk(32'h80000000, 32'h80000000, 0, 32'h80000000), 0, 32'h0, 1, 0, 1, 5};

        repeat (2) @(negedge clk);
        chk("rst_ctrl", {ldM, ldRes, busy, done, none, timeout, winner}, 0);
        chk("rst_data", a_v[0] | a_v[1] | a_v[2] | a_v[3] | result | 32'(iter_count), 0);
        rst = 1'b1;

        for (int k = 0; k < 8; k++) begin
            ovr = tbl[k].ovr;
            ov  = tbl[k].ov;
            run(tbl[k].iv, 0, '0, dc);
            chk($sformatf("row%0d_done_cycle", k), dc, tbl[k].dc);
            chk($sformatf("row%0d_winner", k), winner, tbl[k].w);
            chk($sformatf("row%0d_result", k), result, tbl[k].r);
            chk($sformatf("row%0d_none", k), none, tbl[k].n);
            chk($sformatf("row%0d_timeout", k), timeout, tbl[k].t);
            chk($sformatf("row%0d_iter", k), iter_count, tbl[k].it);
            chk($sformatf("row%0d_load_busy", k), c1_busy, 1);
            chk($sformatf("row%0d_load_clear", k), c1_flags, 0);
            if (!tbl[k].ovr && !tbl[k].t) chk($sformatf("row%0d_act", k), a_v[tbl[k].w], tbl[k].r);
            @(negedge clk);
            chk($sformatf("row%0d_done_pulse", k), {busy, done}, 0);
        end
        ovr = 1'b0;

        // Reset during ACC of the second iteration.
        iv = tbl[0].iv;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_acc_phase", ldRes, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {ldM, ldRes, busy, done, none, timeout, winner}, 0);
        chk("mid_rst_data", a_v[0] | a_v[1] | result | 32'(iter_count), 0);
        dc = 0;
        repeat (3) begin
            @(negedge clk);
            dc += int'(done);
        end
        chk("mid_rst_no_done", dc, 0);
        rst = 1'b1;
        run(tbl[0].iv, 0, '0, dc);
        chk("post_rst_done_cycle", dc, 11);
        chk("post_rst_result", result, 32'h3F4E0000);
        chk("post_rst_iter", iter_count, 3);

        // Start pulsed during MUL with a different vector must be ignored.
        run(tbl[0].iv, 2, tbl[1].iv, dc);
        chk("busy_start_done_cycle", dc, 11);
        chk("busy_start_winner", winner, 0);
        chk("busy_start_result", result, 32'h3F4E0000);
        chk("busy_start_flags", {none, timeout, iter_count}, 7'd3);

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : r2f(real'($urandom_range(1, 32)) / 16.0);
                if ($urandom_range(0, 7) == 0) v[i][31] = 1'b1;
            end
            model(v, ew, er, en, et, eit, fin);
            run(v, 0, '0, dc);
            chk($sformatf("rnd%0d_done_cycle", n), dc, 2 + 3 * eit);
            chk($sformatf("rnd%0d_winner", n), winner, ew);
            chk($sformatf("rnd%0d_result", n), result, er);
            chk($sformatf("rnd%0d_flags", n), {none, timeout}, {en, et});
            chk($sformatf("rnd%0d_iter", n), iter_count, eit);
            for (int i = 0; i < 4; i++) chk($sformatf("rnd%0d_a%0d", n, i + 1), a_v[i], fin[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
